// File: rtl/wb_reg_writer.sv
// Register-file write arbiter: merges ALU results and in-order load returns into
// a single registered write port, with a small write buffer and load tracker.
module wb_reg_writer #(
    parameter int BUF_DEPTH = 2,
    parameter int LD_DEPTH  = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        alu_valid,
    input  logic [4:0]  alu_rd,
    input  logic [31:0] alu_data,
    input  logic        ld_issue,
    input  logic [4:0]  ld_issue_rd,
    input  logic        ld_valid,
    input  logic [31:0] ld_data,
    output logic [4:0]  rd,
    output logic [31:0] data,
    output logic [31:0] busy,
    output logic        stall,
    output logic        ld_full,
    output logic        err
);

    localparam int BW = $clog2(BUF_DEPTH + 1);
    localparam int LW = $clog2(LD_DEPTH + 1);

    logic [4:0]    wb_rd     [BUF_DEPTH];
    logic [31:0]   wb_data   [BUF_DEPTH];
    logic [BW-1:0] wb_cnt;
    logic [4:0]    trk_rd    [LD_DEPTH];
    logic [LW-1:0] trk_cnt;

    logic [4:0]    wb_rd_n   [BUF_DEPTH];
    logic [31:0]   wb_data_n [BUF_DEPTH];
    logic [BW-1:0] wb_cnt_n;
    logic [4:0]    trk_rd_n  [LD_DEPTH];
    logic [LW-1:0] trk_cnt_n;
    logic [4:0]    rd_n;
    logic [31:0]   data_n;
    logic          err_n;

    logic          ld_ev;
    logic [4:0]    ld_ev_rd;
    logic          alu_ev;
    logic [1:0]    push_v;
    logic [4:0]    push_rd   [2];
    logic [31:0]   push_data [2];

    assign stall   = (wb_cnt != '0);
    assign ld_full = (trk_cnt == LW'(LD_DEPTH));

    always_comb begin
        trk_rd_n  = trk_rd;
        trk_cnt_n = trk_cnt;
        wb_rd_n   = wb_rd;
        wb_data_n = wb_data;
        wb_cnt_n  = wb_cnt;
        err_n     = err;
        rd_n      = '0;
        data_n    = '0;
        ld_ev     = 1'b0;
        ld_ev_rd  = '0;
        alu_ev    = 1'b0;
        push_v    = '0;
        push_rd   = '{default: '0};
        push_data = '{default: '0};

        // Tracker pops before it pushes, so a full tracker accepts issue+return together.
        if (ld_valid) begin
            if (trk_cnt == '0) begin
                err_n = 1'b1;
            end else begin
                ld_ev    = (trk_rd[0] != '0);
                ld_ev_rd = trk_rd[0];
                for (int unsigned i = 0; i < LD_DEPTH - 1; i++)
                    trk_rd_n[i] = trk_rd[i+1];
                trk_cnt_n = trk_cnt - LW'(1);
            end
        end
        if (ld_issue) begin
            if (ld_full && !ld_valid) begin
                err_n = 1'b1;
            end else begin
                for (int unsigned i = 0; i < LD_DEPTH; i++)
                    if (trk_cnt_n == LW'(i)) trk_rd_n[i] = ld_issue_rd;
                trk_cnt_n = trk_cnt_n + LW'(1);
            end
        end

        if (alu_valid) begin
            if (stall) err_n = 1'b1;
            else       alu_ev = (alu_rd != '0);
        end

        if (wb_cnt != '0) begin
            rd_n   = wb_rd[0];
            data_n = wb_data[0];
            for (int unsigned i = 0; i < BUF_DEPTH - 1; i++) begin
                wb_rd_n[i]   = wb_rd[i+1];
                wb_data_n[i] = wb_data[i+1];
            end
            wb_cnt_n     = wb_cnt - BW'(1);
            push_v[0]    = ld_ev;
            push_rd[0]   = ld_ev_rd;
            push_data[0] = ld_data;
            push_v[1]    = alu_ev;
            push_rd[1]   = alu_rd;
            push_data[1] = alu_data;
        end else if (ld_ev) begin
            rd_n         = ld_ev_rd;
            data_n       = ld_data;
            push_v[0]    = alu_ev;
            push_rd[0]   = alu_rd;
            push_data[0] = alu_data;
        end else if (alu_ev) begin
            rd_n   = alu_rd;
            data_n = alu_data;
        end

        for (int unsigned k = 0; k < 2; k++) begin
            if (push_v[k]) begin
                if (wb_cnt_n == BW'(BUF_DEPTH)) begin
                    err_n = 1'b1;
                end else begin
                    for (int unsigned i = 0; i < BUF_DEPTH; i++) begin
                        if (wb_cnt_n == BW'(i)) begin
                            wb_rd_n[i]   = push_rd[k];
                            wb_data_n[i] = push_data[k];
                        end
                    end
                    wb_cnt_n = wb_cnt_n + BW'(1);
                end
            end
        end
    end

    always_comb begin
        busy = '0;
        for (int unsigned i = 0; i < LD_DEPTH; i++)
            if (LW'(i) < trk_cnt) busy[trk_rd[i]] = 1'b1;
        for (int unsigned i = 0; i < BUF_DEPTH; i++)
            if (BW'(i) < wb_cnt) busy[wb_rd[i]] = 1'b1;
        busy[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned i = 0; i < BUF_DEPTH; i++) begin
                wb_rd[i]   <= '0;
                wb_data[i] <= '0;
            end
            for (int unsigned i = 0; i < LD_DEPTH; i++)
                trk_rd[i] <= '0;
            wb_cnt  <= '0;
            trk_cnt <= '0;
            rd      <= '0;
            data    <= '0;
            err     <= 1'b0;
        end else begin
            wb_rd   <= wb_rd_n;
            wb_data <= wb_data_n;
            trk_rd  <= trk_rd_n;
            wb_cnt  <= wb_cnt_n;
            trk_cnt <= trk_cnt_n;
            rd      <= rd_n;
            data    <= data_n;
            err     <= err_n;
        end
    end

endmodule
